// File: rtl/vga_plot_arbiter_if.sv
// Pixel-write bus between the drawing datapaths and the plot arbiter, plus the
// arbiter's plot port toward the VGA adapter.
interface vga_plot_arbiter_if;
    logic [2:0]  src_valid;
    logic [2:0]  src_ready;
    logic [14:0] src0_coord;
    logic [14:0] src1_coord;
    logic [14:0] src2_coord;
    logic [8:0]  src0_colour;
    logic [8:0]  src1_colour;
    logic [8:0]  src2_colour;
    logic        vga_hold;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [8:0]  vga_colour;
    logic        vga_plot;

    modport slave (
        input  src_valid, src0_coord, src1_coord, src2_coord,
               src0_colour, src1_colour, src2_colour, vga_hold,
        output src_ready, vga_x, vga_y, vga_colour, vga_plot
    );

    modport master (
        output src_valid, src0_coord, src1_coord, src2_coord,
               src0_colour, src1_colour, src2_colour, vga_hold,
        input  src_ready, vga_x, vga_y, vga_colour, vga_plot
    );
endinterface

// File: rtl/vga_plot_arbiter.sv
// Round-robin merge of three pixel-write sources into a FIFO that drains into
// the VGA adapter plot port at one pixel per cycle; off-screen pixels are dropped.
module vga_plot_lane (
    input  logic [14:0] coord,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic        on_screen
);
    assign x         = coord[14:7];
    assign y         = coord[6:0];
    assign on_screen = (x < 8'd160) && (y < 7'd120);
endmodule

module vga_plot_arbiter #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    vga_plot_arbiter_if.slave    bus,
    output logic [CNT_W-1:0]     fifo_count,
    output logic [15:0]          drop_count
);
    localparam int NUM_SRC = 3;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [8:0] colour;
    } pixel_t;

    logic [NUM_SRC-1:0][14:0] coord;
    logic [NUM_SRC-1:0][8:0]  colour;
    logic [NUM_SRC-1:0][7:0]  lane_x;
    logic [NUM_SRC-1:0][6:0]  lane_y;
    logic [NUM_SRC-1:0]       lane_ok;

    assign coord  = {bus.src2_coord, bus.src1_coord, bus.src0_coord};
    assign colour = {bus.src2_colour, bus.src1_colour, bus.src0_colour};

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_lane
        vga_plot_lane u_lane (
            .coord     (coord[g]),
            .x         (lane_x[g]),
            .y         (lane_y[g]),
            .on_screen (lane_ok[g])
        );
    end

    logic [1:0]       last_grant;
    logic [1:0]       start;
    logic [1:0]       cand;
    logic [1:0]       gnt_idx;
    logic             gnt_any;
    logic             has_room;
    logic             xfer;
    logic             push;
    logic             drop;
    logic             pop;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    pixel_t           mem [FIFO_DEPTH];
    pixel_t           out_px;
    logic             plot_q;

    // Search starts one past the last winner so every source waits at most two transfers.
    always_comb begin
        gnt_idx = 2'd0;
        gnt_any = 1'b0;
        cand    = 2'd0;
        start   = (last_grant == 2'd2) ? 2'd0 : last_grant + 2'd1;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = 2'((int'(start) + k) % NUM_SRC);
            if (!gnt_any && bus.src_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // Room is judged on current occupancy only; a same-cycle pop earns no credit.
    assign has_room      = fifo_count < CNT_W'(FIFO_DEPTH);
    assign xfer          = resetn && gnt_any && has_room;
    assign bus.src_ready = xfer ? (NUM_SRC'(1) << gnt_idx) : '0;
    assign push          = xfer && lane_ok[gnt_idx];
    assign drop          = xfer && !lane_ok[gnt_idx];
    assign pop           = (fifo_count != '0) && !bus.vga_hold;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{x: lane_x[gnt_idx], y: lane_y[gnt_idx], colour: colour[gnt_idx]};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_grant <= 2'd2;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            drop_count <= '0;
            out_px     <= '0;
            plot_q     <= 1'b0;
        end else begin
            if (xfer)
                last_grant <= gnt_idx;
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                out_px <= mem[rd_ptr];
            end
            plot_q     <= pop;
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
            if (drop && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
        end
    end

    assign bus.vga_x      = out_px.x;
    assign bus.vga_y      = out_px.y;
    assign bus.vga_colour = out_px.colour;
    assign bus.vga_plot   = plot_q;
endmodule
